alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one instance of the team's 64-bit ALU (module ALU; ports a, b, control, result, carry, of) between NUM_REQ requesters.
- Each requester presents operands and an op code over a valid/ready handshake.
- A round-robin arbiter grants one request at a time and captures its operands.
- The block sequences the ALU through a 3-state FSM and returns the registered result, tagged with the requester ID, on a single valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/result width; must match the ALU.
- ID_W, 2, width of rsp_id; equals clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NUM_REQ*WIDTH  packed operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  packed operand B, same slicing as req_a.
- req_op  in  NUM_REQ*2  packed op code: 00 add, 01 sub, 10 and, 11 xor.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  WIDTH  ALU result.
- rsp_carry  out  1  ALU carry (borrow for sub); 0 for and/xor.
- rsp_of  out  1  ALU signed overflow; 0 for and/xor.

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_carry=0, rsp_of=0, operand/op registers=0, RR pointer=0.
- req_ready is combinational. It is 0 during reset and in every state except IDLE.
- IDLE:
  - Grant g is the first requester with req_valid high, searching from the RR pointer upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 in the same cycle.
  - At the clock edge: latch req_a[g], req_b[g], req_op[g] and the ID g; set pointer = (g+1) mod NUM_REQ; go to EXEC.
  - If no req_valid is high, stay in IDLE and leave the pointer unchanged.
- EXEC:
  - The ALU is driven only from the latched registers, never directly from req_* inputs.
  - At the edge: register result, carry, of and the ID into the rsp_* registers; set rsp_valid=1; go to RESP.
- RESP:
  - Hold all rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1: at the edge clear rsp_valid and go to IDLE. rsp_result/carry/of/id keep their last values.
- Latency: request accept edge to rsp_valid high is 2 cycles. Minimum spacing between accepts is 3 cycles.
- Requester rules:
  - A requester keeps req_valid and its operands stable until it sees req_ready.
  - A requester may drop req_valid before grant; it is then simply not selected.
- Simultaneous requests: exactly one is granted. Repeated contention therefore serves requesters in strict rotation.
- rsp_ready high outside RESP has no effect.
- Reset asserted mid-operation: the in-flight operation is discarded with no response. All registers take reset values at that edge, including the pointer.
- Arithmetic: the block performs none. Carry and overflow come directly from the ALU, with width WIDTH and no truncation or extension.

Decomposition:
- Shared package alu_pkg: op code constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11) and FSM state encodings.
- Sub-module rr_arbiter(NUM_REQ): inputs req vector and pointer; outputs one-hot grant and encoded index. It is purely combinational.
- The FSM, registers and ALU instance live in alu_req_arbiter.

Test Plan:
- Single add, requester 0: a=293031, b=12, op=00, rsp_ready=1 → req_ready[0] for 1 cycle; rsp_valid 2 cycles after accept; result=293043, carry=0, of=0, rsp_id=0.
- Overflow, requester 2: add a=64'h7FFF_FFFF_FFFF_FFFF, b=1 → result=64'h8000_0000_0000_0000, of=1, carry=0, rsp_id=2.
- Round robin: all 4 requesters valid continuously (sub 4-(-2), and 5938913&4228049, xor 4849129^1147280, add 1+1) → grants in order 0,1,2,3,0; each result correct (sub result=6); accepts spaced exactly 3 cycles apart.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable; no req_ready asserted; one cycle after rsp_ready=1 the FSM returns to IDLE and the next grant is issued.
- Reset mid-op: assert rst_n=0 during EXEC → next cycle rsp_valid=0, state IDLE, pointer=0; the discarded request is not answered, and after release it is re-granted if still valid.
- Idle hold: no req_valid for 10 cycles → no req_ready, rsp_valid=0, pointer unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request arbiter: op codes and FSM state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/ALU.sv
// Shared 64-bit ALU: add/sub/and/xor with carry (borrow on sub) and signed overflow.
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             of
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Result, carry and overflow selection per op code
  always_comb begin
    result = '0;
    carry  = 1'b0;
    of     = 1'b0;
    case (control)
      OP_ADD: begin
        result = sum_s[WIDTH-1:0];
        carry  = sum_s[WIDTH];
        of     = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff_s[WIDTH-1:0];
        carry  = diff_s[WIDTH];
        of     = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: begin
        result = a & b;
      end
      OP_XOR: begin
        result = a ^ b;
      end
      default: begin
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first active request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0] sum_s;
  logic [SW-1:0] pos_s;
  logic          hit_s;

  // Scan requesters starting at ptr; ptr and offset are both below NUM_REQ so one wrap suffices
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum_s = '0;
    pos_s = '0;
    hit_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum_s = {1'b0, ptr} + SW'(i);
      pos_s = (sum_s >= SW'(NUM_REQ)) ? (sum_s - SW'(NUM_REQ)) : sum_s;
      hit_s = !any && req[pos_s[ID_W-1:0]];
      grant[pos_s[ID_W-1:0]] = grant[pos_s[ID_W-1:0]] | hit_s;
      idx   = hit_s ? pos_s[ID_W-1:0] : idx;
      any   = any | hit_s;
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, IDLE/EXEC/RESP sequencing,
// registered result tagged with the requester ID on a valid/ready response port.
module alu_req_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 64,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]     req_op,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_of
);

  state_e             state_r;
  state_e             state_s;
  logic [ID_W-1:0]    ptr_r;
  logic [ID_W-1:0]    ptr_nxt_s;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [1:0]         op_r;
  logic [ID_W-1:0]    id_r;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    idx_s;
  logic               any_s;
  logic [WIDTH-1:0]   alu_result_s;
  logic               alu_carry_s;
  logic               alu_of_s;
  logic               accept_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (idx_s),
    .any   (any_s)
  );

  // The ALU only ever sees the captured operands
  ALU #(.WIDTH(WIDTH)) u_alu (
    .a       (a_r),
    .b       (b_r),
    .control (op_r),
    .result  (alu_result_s),
    .carry   (alu_carry_s),
    .of      (alu_of_s)
  );

  // Grant is offered only while idle and out of reset
  always_comb begin
    req_ready = '0;
    accept_s  = 1'b0;
    if (rst_n && (state_r == IDLE)) begin
      req_ready = grant_s;
      accept_s  = any_s;
    end else begin
      req_ready = '0;
      accept_s  = 1'b0;
    end
  end

  // Pointer advances past the granted requester, wrapping at NUM_REQ
  always_comb begin
    ptr_nxt_s = '0;
    if (idx_s == ID_W'(NUM_REQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = idx_s + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) state_s = EXEC;
        else       state_s = IDLE;
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_ready) state_s = IDLE;
        else           state_s = RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Capture of the granted request and pointer update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= 2'b00;
      id_r  <= '0;
      ptr_r <= '0;
    end else if (accept_s) begin
      a_r   <= req_a[idx_s*WIDTH +: WIDTH];
      b_r   <= req_b[idx_s*WIDTH +: WIDTH];
      op_r  <= req_op[idx_s*2 +: 2];
      id_r  <= idx_s;
      ptr_r <= ptr_nxt_s;
    end
  end

  // Response registers: loaded from the ALU in EXEC, held until the consumer takes them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_of     <= 1'b0;
    end else if (state_r == EXEC) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= id_r;
      rsp_result <= alu_result_s;
      rsp_carry  <= alu_carry_s;
      rsp_of     <= alu_of_s;
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter: expectations queued at drive time, checked on response.
module tb_alu_req_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic [7:0]   req_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic         rsp_carry;
  logic         rsp_of;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] res;
    logic        c;
    logic        o;
  } exp_t;

  exp_t sbq[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;

  alu_req_arbiter #(.NUM_REQ(4), .WIDTH(64), .ID_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_of     (rsp_of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // Reference behaviour of the shared ALU, phrased in signed/unsigned comparisons
  function automatic exp_t model(input logic [1:0] id, input logic [63:0] a, input logic [63:0] b,
                                 input logic [1:0] op);
    exp_t e;
    e.id = id;
    e.c  = 1'b0;
    e.o  = 1'b0;
    case (op)
      2'b00: begin
        e.res = a + b;
        e.c   = (e.res < a);
        e.o   = (($signed(a) < 0) == ($signed(b) < 0)) && (($signed(e.res) < 0) != ($signed(a) < 0));
      end
      2'b01: begin
        e.res = a - b;
        e.c   = (a < b);
        e.o   = (($signed(a) < 0) != ($signed(b) < 0)) && (($signed(e.res) < 0) != ($signed(a) < 0));
      end
      2'b10:   e.res = a & b;
      default: e.res = a ^ b;
    endcase
    return e;
  endfunction

  task automatic drv(input int i, input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                     input bit push);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
    req_op[i*2 +: 2]  = op;
    req_valid[i]      = 1'b1;
    if (push) sbq.push_back(model(2'(i), a, b, op));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Runs cycles until n responses are consumed; checks grant order, latency and optional accept spacing
  task automatic serve(input string name, input int n, input bit drop, input bit spacing, input int acc0);
    int   cyc = 0;
    int   acc_cyc = acc0;
    int   done = 0;
    exp_t e;
    logic [3:0] dropm;
    while (done < n && cyc < 20 * n + 20) begin
      @(negedge clk);
      dropm = 4'b0000;
      if ((req_ready & req_valid) != 4'b0000) begin
        check_cnt++;
        if (sbq.size() == 0 || req_ready !== (4'b0001 << sbq[0].id))
          $display("FAIL %s grant: got req_ready=%b, required id %0d", name, req_ready,
                   (sbq.size() == 0) ? -1 : int'(sbq[0].id));
        else pass_cnt++;
        if (spacing && acc_cyc > -50) begin
          check_cnt++;
          if (cyc - acc_cyc !== 3)
            $display("FAIL %s spacing: got %0d cycles, required 3", name, cyc - acc_cyc);
          else pass_cnt++;
        end
        acc_cyc = cyc;
        if (drop) dropm = req_ready;
      end
      if (rsp_valid && rsp_ready) begin
        check_cnt++;
        if (sbq.size() == 0) begin
          $display("FAIL %s unexpected response id=%0d result=%h", name, rsp_id, rsp_result);
        end else begin
          e = sbq.pop_front();
          if ({rsp_id, rsp_result, rsp_carry, rsp_of} !== e)
            $display("FAIL %s payload: got id=%0d res=%h c=%b of=%b, required id=%0d res=%h c=%b of=%b",
                     name, rsp_id, rsp_result, rsp_carry, rsp_of, e.id, e.res, e.c, e.o);
          else pass_cnt++;
          check_cnt++;
          if (cyc - acc_cyc !== 2)
            $display("FAIL %s latency: got %0d cycles, required 2", name, cyc - acc_cyc);
          else pass_cnt++;
        end
        done++;
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~dropm;
      cyc++;
    end
    if (done < n) begin
      check_cnt++;
      $display("FAIL %s timeout: got %0d responses, required %0d", name, done, n);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b, required 0000", req_ready);
    else pass_cnt++;
    check_cnt++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_of} !== 68'd0)
      $display("FAIL reset_rsp: got valid=%b id=%0d res=%h c=%b of=%b, required all 0",
               rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_of);
    else pass_cnt++;
    req_valid = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_add();
    rsp_ready = 1'b1;
    drv(0, 64'd293031, 64'd12, 2'b00, 1'b1);
    serve("single_add", 1, 1'b1, 1'b0, -100);
  endtask

  task automatic test_overflow();
    drv(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 1'b1);
    serve("overflow", 1, 1'b1, 1'b0, -100);
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    drv(0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 1'b1);
    drv(1, 64'd5938913, 64'd4228049, 2'b10, 1'b1);
    drv(2, 64'd4849129, 64'd1147280, 2'b11, 1'b1);
    drv(3, 64'd1, 64'd1, 2'b00, 1'b1);
    sbq.push_back(model(2'd0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 2'b01));
    serve("round_robin", 5, 1'b0, 1'b1, -100);
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    int   n = 0;
    exp_t e;
    logic [67:0] hold;
    rsp_ready = 1'b0;
    drv(1, 64'd10, 64'd20, 2'b01, 1'b1);
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_cnt++;
    if (!rsp_valid) $display("FAIL bp_wait: got rsp_valid=0, required 1");
    else pass_cnt++;
    hold = {rsp_id, rsp_result, rsp_carry, rsp_of};
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    drv(3, 64'hFFFF_FFFF_0000_0000, 64'h1234_5678_9ABC_DEF0, 2'b11, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_cnt++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_of} !== {1'b1, hold} || req_ready !== 4'b0000)
        $display("FAIL bp_hold: got valid=%b res=%h ready=%b, required valid=1 res=%h ready=0000",
                 rsp_valid, rsp_result, req_ready, hold[65:2]);
      else pass_cnt++;
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_cnt++;
    e = sbq.pop_front();
    if (!rsp_valid || {rsp_id, rsp_result, rsp_carry, rsp_of} !== e)
      $display("FAIL bp_payload: got valid=%b id=%0d res=%h c=%b, required id=%0d res=%h c=%b",
               rsp_valid, rsp_id, rsp_result, rsp_carry, e.id, e.res, e.c);
    else pass_cnt++;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL bp_next_grant: got %b, required 1000", req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    serve("bp_next", 1, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    rsp_ready = 1'b1;
    drv(2, 64'hF0F0, 64'hFF00, 2'b10, 1'b0);
    @(negedge clk);
    while (req_ready[2] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL rst_accept: got %b, required 0100", req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b, required 0000", req_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drv(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b00, 1'b0);
    @(negedge clk);
    check_cnt++;
    if (rsp_valid !== 1'b0 || rsp_result !== 64'd0 || req_ready !== 4'b0100)
      $display("FAIL rst_after: got valid=%b res=%h ready=%b, required valid=0 res=0 ready=0100",
               rsp_valid, rsp_result, req_ready);
    else pass_cnt++;
    sbq.push_back(model(2'd2, 64'hF0F0, 64'hFF00, 2'b10));
    sbq.push_back(model(2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b00));
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    serve("rst_regrant", 2, 1'b1, 1'b0, -1);
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    req_valid = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) bad++;
      @(posedge clk);
      #1;
    end
    check_cnt++;
    if (bad != 0) $display("FAIL idle_hold: got %0d active cycles, required 0", bad);
    else pass_cnt++;
    drv(3, 64'd100, 64'd58, 2'b01, 1'b0);
    drv(1, 64'hAAAA, 64'h5555, 2'b11, 1'b0);
    sbq.push_back(model(2'd1, 64'hAAAA, 64'h5555, 2'b11));
    sbq.push_back(model(2'd3, 64'd100, 64'd58, 2'b01));
    serve("idle_ptr", 2, 1'b1, 1'b0, -100);
  endtask

  initial begin
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    test_reset();
    test_single_add();
    test_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_idle_hold();
    check_cnt++;
    if (sbq.size() != 0) $display("FAIL leftover: got %0d pending, required 0", sbq.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
